alu_issue_stage: RTL and testbench

- Operand-fetch/issue and writeback stage wrapped around the 16-bit ALU.
- Accepts one instruction per handshake, reads two operands from an 8-entry register file, and drives registered OP/INPUTA/INPUTB into the ALU.
- Samples the ALU's OUT/ZERO/EQUAL one cycle later, writes the result back, and latches the flags for downstream branch logic.

---
 rtl/alu_issue_stage.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue and writeback stage around a 16-bit combinational ALU.
// Optional build macro ALU_ISSUE_R0_ZERO_EN makes R0 a hard-wired zero register.
module alu_issue_stage #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    input  logic [15:0]       INSTR,
    output logic [2:0]        ALU_OP,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic              ALU_ZERO,
    input  logic              ALU_EQUAL,
    output logic              DONE,
    output logic [DATA_W-1:0] RESULT,
    output logic [2:0]        RD_OUT,
    output logic              ZERO_FLAG,
    output logic              EQUAL_FLAG,
    input  logic [2:0]        DBG_ADDR,
    output logic [DATA_W-1:0] DBG_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_rf [NREGS];
    logic [2:0]        r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_rd;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic [2:0]        r_rd_out;
    logic              r_zero_flag;
    logic              r_equal_flag;

    logic              w_accept;
    logic [2:0]        w_op;
    logic [2:0]        w_rd;
    logic [2:0]        w_ra;
    logic [2:0]        w_rb;
    logic              w_imm_sel;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;
    logic              w_wr_en;

    // Register-file read port; R0 may be forced to zero in the optional build.
    function automatic logic [DATA_W-1:0] rf_read(input logic [2:0] addr,
                                                  input logic [DATA_W-1:0] data);
`ifdef ALU_ISSUE_R0_ZERO_EN
        if (addr == 3'd0) begin
            return {DATA_W{1'b0}};
        end else begin
            return data;
        end
`else
        return (addr == addr) ? data : data;
`endif
    endfunction

    assign w_op      = INSTR[15:13];
    assign w_rd      = INSTR[12:10];
    assign w_ra      = INSTR[9:7];
    assign w_imm_sel = INSTR[6];
    assign w_rb      = INSTR[5:3];
    assign w_imm     = {{(DATA_W-6){1'b0}}, INSTR[5:0]};

    assign INSTR_READY = (r_state != ST_EXEC);
    assign w_accept    = INSTR_VALID && INSTR_READY;

    // Operands are read from the RF as it stands at the accept edge, so a
    // WB-cycle accept already sees the value written at the end of EXEC.
    assign w_opa = rf_read(w_ra, r_rf[w_ra]);
    assign w_opb = w_imm_sel ? w_imm : rf_read(w_rb, r_rf[w_rb]);

`ifdef ALU_ISSUE_R0_ZERO_EN
    assign w_wr_en = (r_state == ST_EXEC) && (r_rd != 3'd0);
`else
    assign w_wr_en = (r_state == ST_EXEC);
`endif

    assign DBG_DATA = rf_read(DBG_ADDR, r_rf[DBG_ADDR]);

    // Issue/writeback control, operand registers, register file and result flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_alu_op     <= 3'd0;
            r_alu_a      <= {DATA_W{1'b0}};
            r_alu_b      <= {DATA_W{1'b0}};
            r_rd         <= 3'd0;
            r_done       <= 1'b0;
            r_result     <= {DATA_W{1'b0}};
            r_rd_out     <= 3'd0;
            r_zero_flag  <= 1'b0;
            r_equal_flag <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= {DATA_W{1'b0}};
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_state      <= ST_WB;
                    r_result     <= ALU_OUT;
                    r_rd_out     <= r_rd;
                    r_zero_flag  <= ALU_ZERO;
                    r_equal_flag <= ALU_EQUAL;
                    r_done       <= 1'b1;
                end
                ST_WB: begin
                    if (w_accept) begin
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_wr_en) begin
                r_rf[r_rd] <= ALU_OUT;
            end

            if (w_accept) begin
                r_alu_op <= w_op;
                r_alu_a  <= w_opa;
                r_alu_b  <= w_opb;
                r_rd     <= w_rd;
            end
        end
    end

    assign ALU_OP     = r_alu_op;
    assign ALU_A      = r_alu_a;
    assign ALU_B      = r_alu_b;
    assign DONE       = r_done;
    assign RESULT     = r_result;
    assign RD_OUT     = r_rd_out;
    assign ZERO_FLAG  = r_zero_flag;
    assign EQUAL_FLAG = r_equal_flag;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with a behavioural 16-bit ALU.
module tb_alu_issue_stage;

    logic        CLK;
    logic        RESET;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [15:0] INSTR;
    logic [2:0]  ALU_OP;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [15:0] ALU_OUT;
    logic        ALU_ZERO;
    logic        ALU_EQUAL;
    logic        DONE;
    logic [15:0] RESULT;
    logic [2:0]  RD_OUT;
    logic        ZERO_FLAG;
    logic        EQUAL_FLAG;
    logic [2:0]  DBG_ADDR;
    logic [15:0] DBG_DATA;

    int n_checks = 0;
    int n_err    = 0;

    alu_issue_stage #(.DATA_W(16), .NREGS(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR(INSTR),
        .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO), .ALU_EQUAL(ALU_EQUAL),
        .DONE(DONE), .RESULT(RESULT), .RD_OUT(RD_OUT),
        .ZERO_FLAG(ZERO_FLAG), .EQUAL_FLAG(EQUAL_FLAG),
        .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ALU: 0 AND, 1 OR, 2 ADD, 3 byte swap of B, 4 B<<A, 5 SUB, 6/7 zero.
    always_comb begin
        case (ALU_OP)
            3'd0:    ALU_OUT = ALU_A & ALU_B;
            3'd1:    ALU_OUT = ALU_A | ALU_B;
            3'd2:    ALU_OUT = ALU_A + ALU_B;
            3'd3:    ALU_OUT = {ALU_B[7:0], ALU_B[15:8]};
            3'd4:    ALU_OUT = ALU_B << ALU_A[3:0];
            3'd5:    ALU_OUT = ALU_A - ALU_B;
            default: ALU_OUT = 16'h0000;
        endcase
        ALU_ZERO  = (ALU_OUT == 16'h0000);
        ALU_EQUAL = (ALU_A == ALU_B);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dbg_chk(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        DBG_ADDR = addr;
        #1;
        chk(tag, DBG_DATA, exp);
    endtask

    function automatic logic [15:0] enc_imm(input logic [2:0] op, input logic [2:0] rd,
                                            input logic [2:0] ra, input logic [5:0] imm);
        return {op, rd, ra, 1'b1, imm};
    endfunction

    function automatic logic [15:0] enc_reg(input logic [2:0] op, input logic [2:0] rd,
                                            input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, 1'b0, rb, 3'b000};
    endfunction

    // Called at a negedge while the stage is ready; returns just after the accept edge.
    task automatic send(input logic [15:0] instr);
        INSTR_VALID = 1'b1;
        INSTR       = instr;
        @(posedge CLK);
        #1;
        INSTR_VALID = 1'b0;
    endtask

    // Full issue: accept, EXEC, WB checks, then settle in IDLE at a negedge.
    task automatic run(input string tag, input logic [15:0] instr, input logic [15:0] exp_res,
                       input logic [2:0] exp_rd, input logic exp_z, input logic exp_e);
        send(instr);
        @(negedge CLK);
        chk({tag, "_busy"}, {15'd0, INSTR_READY}, 16'h0000);
        @(negedge CLK);
        chk({tag, "_done"}, {15'd0, DONE}, 16'h0001);
        chk({tag, "_res"}, RESULT, exp_res);
        chk({tag, "_rd"}, {13'd0, RD_OUT}, {13'd0, exp_rd});
        chk({tag, "_zf"}, {15'd0, ZERO_FLAG}, {15'd0, exp_z});
        chk({tag, "_ef"}, {15'd0, EQUAL_FLAG}, {15'd0, exp_e});
        @(negedge CLK);
    endtask

    initial begin
        RESET       = 1'b1;
        INSTR_VALID = 1'b0;
        INSTR       = 16'h0000;
        DBG_ADDR    = 3'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);

        // Reset state
        chk("rst_ready", {15'd0, INSTR_READY}, 16'h0001);
        chk("rst_done", {15'd0, DONE}, 16'h0000);
        chk("rst_zf", {15'd0, ZERO_FLAG}, 16'h0000);
        chk("rst_ef", {15'd0, EQUAL_FLAG}, 16'h0000);
        chk("rst_result", RESULT, 16'h0000);
        chk("rst_alu_a", ALU_A, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            dbg_chk("rst_dbg", 3'(i), 16'h0000);
        end
        RESET = 1'b0;
        @(negedge CLK);

        // ADD immediate, then dependent SUB accepted in the WB cycle
        send(enc_imm(3'd2, 3'd1, 3'd0, 6'd5));
        @(negedge CLK);
        chk("add_busy", {15'd0, INSTR_READY}, 16'h0000);
        chk("add_done_early", {15'd0, DONE}, 16'h0000);
        chk("add_alu_op", {13'd0, ALU_OP}, 16'h0002);
        chk("add_alu_b", ALU_B, 16'h0005);
        @(negedge CLK);
        chk("add_done", {15'd0, DONE}, 16'h0001);
        chk("add_res", RESULT, 16'h0005);
        chk("add_rd", {13'd0, RD_OUT}, 16'h0001);
        chk("add_zf", {15'd0, ZERO_FLAG}, 16'h0000);
        chk("add_ef", {15'd0, EQUAL_FLAG}, 16'h0000);
        chk("add_wb_ready", {15'd0, INSTR_READY}, 16'h0001);
        dbg_chk("add_dbg1", 3'd1, 16'h0005);

        send(enc_reg(3'd5, 3'd2, 3'd1, 3'd1));
        @(negedge CLK);
        chk("sub_busy", {15'd0, INSTR_READY}, 16'h0000);
        chk("sub_alu_a", ALU_A, 16'h0005);
        chk("sub_alu_b", ALU_B, 16'h0005);
        @(negedge CLK);
        chk("sub_done", {15'd0, DONE}, 16'h0001);
        chk("sub_res", RESULT, 16'h0000);
        chk("sub_rd", {13'd0, RD_OUT}, 16'h0002);
        chk("sub_zf", {15'd0, ZERO_FLAG}, 16'h0001);
        chk("sub_ef", {15'd0, EQUAL_FLAG}, 16'h0001);
        @(negedge CLK);
        chk("idle_done", {15'd0, DONE}, 16'h0000);
        chk("idle_ready", {15'd0, INSTR_READY}, 16'h0001);

        // Build R3=4 and R4=0x1234
        run("ld_r3", enc_imm(3'd1, 3'd3, 3'd0, 6'd4), 16'h0004, 3'd3, 1'b0, 1'b0);
        run("ld_r4", enc_imm(3'd1, 3'd4, 3'd0, 6'h12), 16'h0012, 3'd4, 1'b0, 1'b0);
        run("shl1", enc_reg(3'd4, 3'd4, 3'd3, 3'd4), 16'h0120, 3'd4, 1'b0, 1'b0);
        run("shl2", enc_reg(3'd4, 3'd4, 3'd3, 3'd4), 16'h1200, 3'd4, 1'b0, 1'b0);
        run("or34", enc_imm(3'd1, 3'd4, 3'd4, 6'h34), 16'h1234, 3'd4, 1'b0, 1'b0);
        dbg_chk("r4_dbg", 3'd4, 16'h1234);

        // Shift, swap, zero op, rd==ra
        run("shift", enc_reg(3'd4, 3'd5, 3'd3, 3'd4), 16'h2340, 3'd5, 1'b0, 1'b0);
        run("swap", enc_reg(3'd3, 3'd6, 3'd4, 3'd4), 16'h3412, 3'd6, 1'b0, 1'b1);
        dbg_chk("swap_dbg6", 3'd6, 16'h3412);
        run("op6", enc_reg(3'd6, 3'd7, 3'd4, 3'd3), 16'h0000, 3'd7, 1'b1, 1'b0);
        dbg_chk("op6_dbg7", 3'd7, 16'h0000);
        run("rd_eq_ra", enc_imm(3'd2, 3'd3, 3'd3, 6'd1), 16'h0005, 3'd3, 1'b0, 1'b0);
        dbg_chk("rd_eq_ra_dbg", 3'd3, 16'h0005);

        // Reset during EXEC drops the writeback
        send(enc_imm(3'd2, 3'd5, 3'd0, 6'd9));
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rx_done", {15'd0, DONE}, 16'h0000);
        chk("rx_ready", {15'd0, INSTR_READY}, 16'h0001);
        chk("rx_result", RESULT, 16'h0000);
        chk("rx_alu_b", ALU_B, 16'h0000);
        dbg_chk("rx_dbg5", 3'd5, 16'h0000);
        @(negedge CLK);
        chk("rx_done2", {15'd0, DONE}, 16'h0000);

        // R0 write
        run("r0", enc_imm(3'd2, 3'd0, 3'd0, 6'd7), 16'h0007, 3'd0, 1'b0, 1'b0);
`ifdef ALU_ISSUE_R0_ZERO_EN
        dbg_chk("r0_dbg", 3'd0, 16'h0000);
`else
        dbg_chk("r0_dbg", 3'd0, 16'h0007);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
